// File: rtl/gate_bist.sv
// Built-in self-test for a 2-input gate: sweeps {dut_a,dut_b} over 00..11 and
// checks dut_y against TRUTH after SETTLE cycles, recording mismatch count and first failure.
//   state | meaning
//   IDLE  | after reset, waiting for start
//   RUN   | applying vectors, settle down-counter running
//   DONE  | results held until next start or reset
module gate_bist #(
  parameter logic [3:0]  TRUTH  = 4'b0001,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       dut_a,
  output logic       dut_b,
  input  logic       dut_y,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [1:0] fail_vec,
  output logic       fail_valid
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE);

  state_t     state, state_nxt;
  logic [1:0] k, k_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [1:0] ab_nxt;
  logic       busy_nxt, done_nxt, pass_nxt, fval_nxt;
  logic [2:0] err_nxt, err_inc;
  logic [1:0] fv_nxt;
  logic       mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      k          <= 2'd0;
      cnt        <= 4'd0;
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= 3'd0;
      fail_vec   <= 2'd0;
      fail_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      k          <= k_nxt;
      cnt        <= cnt_nxt;
      dut_a      <= ab_nxt[1];
      dut_b      <= ab_nxt[0];
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_count  <= err_nxt;
      fail_vec   <= fv_nxt;
      fail_valid <= fval_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    cnt_nxt   = cnt;
    ab_nxt    = {dut_a, dut_b};
    busy_nxt  = busy;
    done_nxt  = done;
    pass_nxt  = pass;
    err_nxt   = err_count;
    fv_nxt    = fail_vec;
    fval_nxt  = fail_valid;
    mismatch  = 1'b0;
    err_inc   = err_count;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = RUN;
          busy_nxt  = 1'b1;
          done_nxt  = 1'b0;
          pass_nxt  = 1'b0;
          err_nxt   = 3'd0;
          fv_nxt    = 2'd0;
          fval_nxt  = 1'b0;
          k_nxt     = 2'd0;
          ab_nxt    = 2'b00;
          cnt_nxt   = SETTLE_LD;
        end
      end
      RUN: begin
        if (cnt != 4'd0) begin
          cnt_nxt = cnt - 4'd1;
        end else begin
          // X on dut_y is treated as a failure
          mismatch = (dut_y !== TRUTH[k]);
          if (mismatch) begin
            err_inc = (err_count == 3'd4) ? err_count : err_count + 3'd1;
            if (!fail_valid) begin
              fv_nxt   = k;
              fval_nxt = 1'b1;
            end
          end
          err_nxt = err_inc;
          if (k != 2'd3) begin
            k_nxt   = k + 2'd1;
            ab_nxt  = k + 2'd1;
            cnt_nxt = SETTLE_LD;
          end else begin
            state_nxt = DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
            pass_nxt  = (err_inc == 3'd0);
            ab_nxt    = 2'b00;
            k_nxt     = 2'd0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- Synthesizable self-checking exerciser for any 2-input logic gate: drives the gate's inputs, samples its output and checks it against a truth table.
- Sweeps all four input combinations, counts mismatches and records the first failing vector.
- Sits alongside the gate models as on-chip/FPGA built-in self-test. Provides the same stimulus/check function as the simulation benches, in hardware.

Parameters:
- TRUTH, 4'b0001, expected output per input vector; bit i = expected dut_y for {dut_a,dut_b} = i. Default is NOR.
- SETTLE, 2, cycles the DUT output is given to settle after a vector is applied. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a test run; sampled only when not busy.
- dut_a  output  1  gate input A (registered).
- dut_b  output  1  gate input B (registered).
- dut_y  input  1  gate output under test.
- busy  output  1  high while a run is in progress.
- done  output  1  high from run completion until the next accepted start or reset.
- pass  output  1  valid while done; 1 when err_count == 0.
- err_count  output  3  number of mismatching vectors, 0..4.
- fail_vec  output  2  {a,b} of the first mismatch; valid when fail_valid.
- fail_valid  output  1  at least one mismatch recorded this run.

Behaviour:
- Reset: all outputs 0 (dut_a, dut_b, busy, done, pass, err_count, fail_vec, fail_valid). FSM goes to IDLE, vector and settle counters go to 0. Reset takes priority at every edge, including mid-run; the run is aborted and no result is retained.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1 at edge E0:
  - go to RUN, busy=1, done=0, pass=0.
  - clear err_count, fail_vec and fail_valid.
  - vector counter k=0, {dut_a,dut_b}=2'b00, settle counter=SETTLE.
- RUN, each vector k (k = 0..3):
  - The vector is held for SETTLE+1 cycles, from edge E(k*(SETTLE+1)).
  - The settle counter decrements once per cycle.
  - dut_y is sampled at edge E((k+1)*(SETTLE+1)), i.e. the edge where the counter reaches 0; the sampled value is the pre-edge value.
- At a sample edge:
  - mismatch = (dut_y != TRUTH[k]).
  - On mismatch, err_count increments (saturates at 4, which is unreachable anyway).
  - On the first mismatch (fail_valid==0), fail_vec=k and fail_valid=1.
  - If k<3: k increments, the next vector is applied at the same edge, and the settle counter reloads SETTLE.
- Completion: the sample edge for k=3 (E(4*(SETTLE+1))) moves the FSM to DONE.
  - busy=0, done=1, pass=(final err_count==0).
  - {dut_a,dut_b} returns to 2'b00.
  - err_count is final at that same edge.
- start while busy: ignored, with no effect on counters or timing.
- start in DONE: restarts immediately, identical to starting from IDLE.
- Results (done, pass, err_count, fail_*) hold stable in DONE indefinitely.
- Unknown/X on dut_y counts as a mismatch in simulation (compare using !==).

Test Plan:
1. NOR gate attached, default parameters, start pulse at E0 -> vectors 00, 01, 10, 11 each held 3 cycles; done=1, busy=0 after E12; pass=1, err_count=0, fail_valid=0.
2. NAND gate attached (TRUTH=4'b0001) -> done after E12; err_count=2, fail_vec=2'b01, fail_valid=1, pass=0.
3. dut_y tied 0 -> err_count=1, fail_vec=2'b00. dut_y tied 1 -> err_count=3, fail_vec=2'b01.
4. start re-pulsed at E5 during a run -> ignored; done still at E12 with unchanged results. Second start in DONE -> results cleared at the start edge, new run completes 12 cycles later.
5. rst asserted at E7 mid-run -> at the next edge all outputs 0 and FSM in IDLE. A subsequent start runs a clean full sweep.
6. SETTLE=1, NOR attached -> each vector held 2 cycles; done after E8; pass=1.
